// File: rtl/fe.sv
// fe -- instruction fetch stage with PC register and IF/ID pipeline register.
//
// Ports:
//   i_clk, i_rst     clock; synchronous active-high reset
//   i_hold           decode stall: freeze PC and IF/ID
//   i_flush          execute redirect (taken branch) to i_flush_tgt
//   i_jal, i_jalr    decode-stage jumps; target from i_dec_pc / i_jalr_rs1 + i_dec_imm
//   o_imem_raddr     current PC to instruction memory (combinational read)
//   i_imem_rdata     instruction word at o_imem_raddr
//   o_inst, o_pc, o_nxt_pc, o_vld, o_misalign   IF/ID register contents
module fe #(
  parameter logic [31:0] RESET_ADDR = 32'h00000000,
  parameter logic [31:0] NOP        = 32'h00000033
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hold,
  input  logic        i_flush,
  input  logic [31:0] i_flush_tgt,
  input  logic        i_jal,
  input  logic        i_jalr,
  input  logic [31:0] i_dec_pc,
  input  logic [31:0] i_dec_imm,
  input  logic [31:0] i_jalr_rs1,
  output logic [31:0] o_imem_raddr,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic        o_vld,
  output logic        o_misalign
);

  typedef enum logic [1:0] {
    ACT_SEQ,
    ACT_HOLD,
    ACT_JUMP,
    ACT_FLUSH
  } act_e;

  act_e        act;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] redir_tgt;
  logic [31:0] jalr_sum;

  assign o_imem_raddr = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign jalr_sum     = i_jalr_rs1 + i_dec_imm;

  // Priority: flush > hold > jal > jalr > sequential.
  always_comb begin
    act       = ACT_SEQ;
    redir_tgt = pc_plus4;
    if (i_flush) begin
      act       = ACT_FLUSH;
      redir_tgt = i_flush_tgt;
    end else if (i_hold) begin
      act = ACT_HOLD;
    end else if (i_jal) begin
      act       = ACT_JUMP;
      redir_tgt = i_dec_pc + i_dec_imm;
    end else if (i_jalr) begin
      act       = ACT_JUMP;
      redir_tgt = {jalr_sum[31:1], 1'b0};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q       <= RESET_ADDR;
      o_inst     <= NOP;
      o_vld      <= 1'b0;
      o_misalign <= 1'b0;
      o_pc       <= '0;
      o_nxt_pc   <= '0;
    end else begin
      case (act)
        ACT_HOLD: ;
        ACT_FLUSH, ACT_JUMP: begin
          // Bubble: o_pc/o_nxt_pc intentionally keep their previous values.
          pc_q       <= redir_tgt;
          o_inst     <= NOP;
          o_vld      <= 1'b0;
          o_misalign <= 1'b0;
        end
        default: begin
          pc_q       <= pc_plus4;
          o_inst     <= i_imem_rdata;
          o_pc       <= pc_q;
          o_nxt_pc   <= pc_plus4;
          o_vld      <= 1'b1;
          o_misalign <= |pc_q[1:0];
        end
      endcase
    end
  end

endmodule

// File: doc/fe.md
FE -- requirements
Module: fe

Interface
REQ-001 Parameter RESET_ADDR, default 32'h00000000: PC value loaded on reset.
REQ-002 Parameter NOP, default 32'h00000033: instruction word (add x0,x0,x0) placed in IF/ID on bubble or reset.
REQ-003 i_clk  input  1  global clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_hold  input  1  decode stall request; freezes PC and IF/ID.
REQ-006 i_flush  input  1  execute-stage redirect (taken branch).
REQ-007 i_flush_tgt  input  32  redirect target, valid when i_flush=1.
REQ-008 i_jal  input  1  decode holds a valid JAL.
REQ-009 i_jalr  input  1  decode holds a valid JALR.
REQ-010 i_dec_pc  input  32  PC of the instruction in decode.
REQ-011 i_dec_imm  input  32  decoded immediate of the instruction in decode.
REQ-012 i_jalr_rs1  input  32  forwarded rs1 value for JALR.
REQ-013 o_imem_raddr  output  32  instruction memory address (current PC); memory read is combinational.
REQ-014 i_imem_rdata  input  32  instruction word at o_imem_raddr, same cycle.
REQ-015 o_inst  output  32  IF/ID instruction.
REQ-016 o_pc  output  32  IF/ID PC.
REQ-017 o_nxt_pc  output  32  IF/ID PC+4 (link value).
REQ-018 o_vld  output  1  IF/ID instruction valid.
REQ-019 o_misalign  output  1  IF/ID entry was fetched from a target with bits [1:0]!=0.

Function
REQ-020 o_imem_raddr SHALL equal the PC register combinationally.
REQ-021 Redirect target: i_flush -> i_flush_tgt; else i_jal -> i_dec_pc+i_dec_imm; else i_jalr -> (i_jalr_rs1+i_dec_imm) & ~32'h1; all arithmetic modulo 2^32.
REQ-022 Next-PC priority SHALL be i_flush > i_hold > i_jal > i_jalr > PC+4.
REQ-023 i_flush=1: PC <= i_flush_tgt and IF/ID <= bubble, regardless of i_hold, i_jal, i_jalr.
REQ-024 i_hold=1 and i_flush=0: PC and all IF/ID fields SHALL hold their values; i_jal/i_jalr are ignored that cycle.
REQ-025 i_jal or i_jalr (no flush, no hold): PC <= computed target; IF/ID <= bubble (1-cycle penalty for the wrong-path fetch).
REQ-026 No event: PC <= PC+4; IF/ID <= {i_imem_rdata, PC, PC+4, vld=1, misalign=(PC[1:0]!=0)}.
REQ-027 Bubble SHALL be o_inst=NOP, o_vld=0, o_misalign=0; o_pc/o_nxt_pc hold previous values.
REQ-028 A misaligned PC is fetched as-is; o_misalign flags it and trap handling belongs downstream; PC then advances by 4.
REQ-029 PC+4 at 32'hFFFFFFFC SHALL wrap to 32'h00000000.
REQ-030 Latency: the word at PC appears on o_inst one cycle after PC is presented on o_imem_raddr.

Reset
REQ-031 i_rst=1 at an edge: PC <= RESET_ADDR, o_inst <= NOP, o_vld <= 0, o_misalign <= 0, o_pc <= 0, o_nxt_pc <= 0; reset overrides flush, hold and jumps.
REQ-032 The first edge after reset deassertion SHALL load the RESET_ADDR instruction into IF/ID with o_vld=1.
REQ-033 Reset asserted mid-stall or mid-redirect SHALL discard pending state; no residual bubble or hold effect after deassertion.

Verification
REQ-034 Sequential: imem[0]=0x00500093, imem[4]=0x00100113, reset released -> o_imem_raddr 0,4,8; o_inst 0x00500093 then 0x00100113 with o_pc 0,4 and o_nxt_pc 4,8, o_vld=1.
REQ-035 Hold: i_hold=1 for 2 cycles while PC=8 -> o_imem_raddr stays 8, IF/ID unchanged for 2 cycles, then resumes at 8.
REQ-036 JAL: i_jal=1, i_dec_pc=0x10, i_dec_imm=0x20 -> next PC=0x30, next o_vld=0, o_inst=0x00000033.
REQ-037 JALR: i_jalr=1, i_jalr_rs1=0x101, i_dec_imm=0x4 -> next PC=0x104 (bit0 cleared), one bubble.
REQ-038 Flush priority: i_flush=1, i_flush_tgt=0x200, i_hold=1, i_jal=1 in the same cycle -> PC=0x200, bubble in IF/ID, no hold.
REQ-039 Misalign and wrap: i_flush_tgt=0x202 -> IF/ID o_pc=0x202, o_misalign=1; PC=0xFFFFFFFC with no event -> next PC=0x00000000.
